// File: rtl/alu_ops_pkg.sv
// Shared encodings for the bit-serial logic unit: {m,s} function selects and FSM states.
package alu_ops_pkg;

  localparam logic [2:0] OP_PASS_A    = 3'b000;
  localparam logic [2:0] OP_NOT_A     = 3'b001;
  localparam logic [2:0] OP_XOR       = 3'b010;
  localparam logic [2:0] OP_XNOR      = 3'b011;
  localparam logic [2:0] OP_OR        = 3'b110;
  localparam logic [2:0] OP_NOTA_OR_B = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/one_bit_logic_slice.sv
// Combinational one-bit logic slice; {m,s} selects the per-bit function.
module one_bit_logic_slice
  import alu_ops_pkg::*;
(
  input  logic       m,
  input  logic [1:0] s,
  input  logic       a,
  input  logic       b,
  output logic       f
);

  // When s[1] is 0 the mode bit is ignored, so both m values decode alike.
  always_comb begin
    f = 1'b0;
    case ({m, s})
      OP_PASS_A:    f = a;
      OP_NOT_A:     f = ~a;
      3'b100:       f = a;
      3'b101:       f = ~a;
      OP_XOR:       f = a ^ b;
      OP_XNOR:      f = ~(a ^ b);
      OP_OR:        f = a | b;
      OP_NOTA_OR_B: f = (~a) | b;
      default:      f = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic_alu.sv
// Bit-serial WIDTH-bit logic unit: captures a command, streams operands LSB-first
// through one logic slice, and publishes the registered result with a done pulse.
module serial_logic_alu
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             m,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_m;
  logic [1:0]       r_s;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_f;
  logic             r_zero;
  logic             w_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  one_bit_logic_slice u_slice (
    .m (r_m),
    .s (r_s),
    .a (r_a[0]),
    .b (r_b[0]),
    .f (w_bit)
  );

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = {w_bit, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // The counter holds at its last value; only a new capture in IDLE returns it to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m    <= 1'b0;
      r_s    <= 2'b00;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_f    <= '0;
      r_zero <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m    <= m;
            r_s    <= s;
            r_a    <= a;
            r_b    <= b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_res <= w_res_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          if (w_last) begin
            r_f    <= w_res_next;
            r_zero <= (w_res_next == '0);
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: r_done <= 1'b0;
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign f           = r_f;
  assign zero        = r_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_logic_alu.sv
// Directed bench for serial_logic_alu: scoreboard queue of expected {zero,f} popped on each done.
module tb_serial_logic_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         m;
  logic [1:0]   s;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] f;
  logic         zero;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;

  serial_logic_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .m           (m),
    .s           (s),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .f           (f),
    .zero        (zero),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with f=%0h expected no pending result", f);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_f", 32'(f), 32'(mon_e[W-1:0]));
        check("result_zero", 32'(zero), 32'(mon_e[W]));
      end
    end
  end

  // Driver: one command, optional colliding start three cycles in.
  task automatic run_cmd(input logic mm, input logic [1:0] ss, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [W-1:0] ef, input bit collide);
    int lat;
    int nbusy;
    int ndone;
    lat = -1;
    nbusy = 0;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; m = mm; s = ss; a = aa; b = bb;
    exp_q.push_back({(ef == '0), ef});
    @(posedge clk);
    #1;
    for (int c = 0; c < 12; c++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      @(negedge clk);
      start = (collide && c == 3);
      m = ~mm; s = ~ss; a = ~aa; b = ~bb;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("done_latency", 32'(lat), 32'(8));
    check("busy_cycles", 32'(nbusy), 32'(8));
    check("done_count", 32'(ndone), 32'(1));
  endtask

  initial begin
    int dpos[$];
    int ndone;
    bit prev;
    reset = 1'b1; start = 1'b0; m = 1'b0; s = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_f", 32'(f), 32'(0));
    check("reset_zero", 32'(zero), 32'(1));
    check("reset_state", 32'(dbg_state), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    run_cmd(1'b0, 2'b10, 8'hA5, 8'h3C, 8'h99, 1'b0);
    run_cmd(1'b0, 2'b11, 8'hA5, 8'h3C, 8'h66, 1'b0);
    run_cmd(1'b1, 2'b10, 8'hA5, 8'h3C, 8'hBD, 1'b0);
    run_cmd(1'b1, 2'b11, 8'hA5, 8'h3C, 8'h7E, 1'b0);
    run_cmd(1'b0, 2'b00, 8'hA5, 8'h3C, 8'hA5, 1'b0);
    run_cmd(1'b0, 2'b01, 8'hA5, 8'h3C, 8'h5A, 1'b0);
    run_cmd(1'b1, 2'b00, 8'hA5, 8'h3C, 8'hA5, 1'b0);
    run_cmd(1'b1, 2'b01, 8'h0F, 8'h00, 8'hF0, 1'b0);
    run_cmd(1'b0, 2'b10, 8'h5A, 8'h5A, 8'h00, 1'b0);
    run_cmd(1'b0, 2'b11, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    run_cmd(1'b1, 2'b10, 8'h00, 8'h00, 8'h00, 1'b0);
    run_cmd(1'b0, 2'b10, 8'hA5, 8'h3C, 8'h99, 1'b1);

    // Held start: launches every 10 cycles.
    @(negedge clk);
    start = 1'b1; m = 1'b0; s = 2'b10; a = 8'hA5; b = 8'h3C;
    repeat (3) exp_q.push_back({1'b0, 8'h99});
    ndone = 0;
    prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        dpos.push_back(c);
        if (prev) check("done_width", 32'(c), 32'(-1));
      end
      prev = (done === 1'b1);
      if (c == 24) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    check("held_done_count", 32'(ndone), 32'(3));
    if (dpos.size() == 3) begin
      check("held_done_0", 32'(dpos[0]), 32'(8));
      check("held_period_1", 32'(dpos[1] - dpos[0]), 32'(10));
      check("held_period_2", 32'(dpos[2] - dpos[1]), 32'(10));
    end

    // Async reset mid-operation.
    @(negedge clk);
    start = 1'b1; m = 1'b1; s = 2'b10; a = 8'hA5; b = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_f", 32'(f), 32'(0));
    check("abort_zero", 32'(zero), 32'(1));
    check("abort_state", 32'(dbg_state), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'(0));
    run_cmd(1'b1, 2'b11, 8'hA5, 8'h3C, 8'h7E, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
